// File: rtl/fork_join_scheduler.sv
// fork_join_scheduler: launches delayed child jobs on a fork and releases the parent per join mode
module fork_join_scheduler #(
  parameter int NUM_THREADS = 4,
  parameter int DLY_W       = 8,
  parameter int ID_W        = $clog2(NUM_THREADS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [1:0]                   mode,
  input  logic [NUM_THREADS-1:0]       thread_en,
  input  logic [NUM_THREADS*DLY_W-1:0] delays,
  input  logic                         kill,
  output logic                         busy,
  output logic [NUM_THREADS-1:0]       thread_active,
  output logic [NUM_THREADS-1:0]       thread_done,
  output logic                         parent_release,
  output logic [ID_W-1:0]              first_id,
  output logic                         all_done,
  output logic                         aborted
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [1:0] M_JOIN = 2'b00, M_ANY = 2'b01, M_NONE = 2'b10;
  state_t                 state_q, state_d;
  logic [1:0]             mode_q, mode_d;
  logic [DLY_W-1:0]       cnt_q [NUM_THREADS];
  logic [DLY_W-1:0]       cnt_d [NUM_THREADS];
  logic [NUM_THREADS-1:0] active_q, active_d, done_q, done_d, fin;
  logic                   release_q, release_d, all_done_q, all_done_d, aborted_q, aborted_d;
  logic                   released_q, released_d, empty_q, empty_d, last, rel_ok;
  logic [ID_W-1:0]        first_q, first_d, low_id;
  // Next-state: load on fork, count down while running, detect join conditions and kill
  always_comb begin
    fin = '0;
    for (int i = 0; i < NUM_THREADS; i++) fin[i] = active_q[i] && (cnt_q[i] == '0);
    low_id = '0;
    for (int i = NUM_THREADS-1; i >= 0; i--) if (fin[i]) low_id = ID_W'(i);
    last = (|fin) && ((active_q & ~fin) == '0);
    rel_ok = !released_q && ((mode_q == M_NONE) || (mode_q == M_ANY && |fin) || (mode_q == M_JOIN && last));
    state_d = state_q;
    mode_d = mode_q;
    cnt_d = cnt_q;
    active_d = active_q;
    done_d = '0;
    release_d = 1'b0;
    all_done_d = 1'b0;
    aborted_d = 1'b0;
    released_d = released_q;
    empty_d = 1'b0;
    first_d = first_q;
    if (state_q == IDLE) begin
      release_d = empty_q;
      all_done_d = empty_q;
      if (start && thread_en == '0) begin
        empty_d = 1'b1;
        first_d = '0;
      end else if (start) begin
        mode_d = (mode == 2'b11) ? M_JOIN : mode;
        for (int i = 0; i < NUM_THREADS; i++) cnt_d[i] = thread_en[i] ? delays[i*DLY_W +: DLY_W] : '0;
        active_d = thread_en;
        released_d = 1'b0;
        state_d = RUN;
      end
    end else if (kill) begin
      for (int i = 0; i < NUM_THREADS; i++) cnt_d[i] = '0;
      active_d = '0;
      aborted_d = 1'b1;
      state_d = IDLE;
    end else begin
      for (int i = 0; i < NUM_THREADS; i++) cnt_d[i] = (active_q[i] && !fin[i]) ? cnt_q[i] - 1'b1 : cnt_q[i];
      done_d = fin;
      active_d = active_q & ~fin;
      all_done_d = last;
      state_d = last ? IDLE : RUN;
      release_d = rel_ok;
      released_d = released_q | rel_ok;
      first_d = (rel_ok && mode_q == M_ANY) ? low_id : first_q;
    end
  end
  // State and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q <= M_JOIN;
      cnt_q <= '{default: '0};
      active_q <= '0;
      done_q <= '0;
      release_q <= 1'b0;
      all_done_q <= 1'b0;
      aborted_q <= 1'b0;
      released_q <= 1'b0;
      empty_q <= 1'b0;
      first_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      cnt_q <= cnt_d;
      active_q <= active_d;
      done_q <= done_d;
      release_q <= release_d;
      all_done_q <= all_done_d;
      aborted_q <= aborted_d;
      released_q <= released_d;
      empty_q <= empty_d;
      first_q <= first_d;
    end
  end
  assign busy = (state_q == RUN);
  assign thread_active = active_q;
  assign thread_done = done_q;
  assign parent_release = release_q;
  assign first_id = first_q;
  assign all_done = all_done_q;
  assign aborted = aborted_q;
endmodule

// File: tb/tb_fork_join_scheduler.sv
// tb_fork_join_scheduler: scoreboard bench checking pulse timing of the fork/join scheduler
module tb_fork_join_scheduler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  thread_en = '0;
  logic [31:0] delays = '0;
  logic        kill = 1'b0;
  logic        busy, parent_release, all_done, aborted;
  logic [3:0]  thread_active, thread_done;
  logic [1:0]  first_id;
  int cyc = 0;
  int tests = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  typedef struct {int c; logic [3:0] dm; logic rel; logic ad; logic ab;} exp_t;
  exp_t q[$];

  fork_join_scheduler #(.NUM_THREADS(4), .DLY_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .thread_en(thread_en),
    .delays(delays), .kill(kill), .busy(busy), .thread_active(thread_active),
    .thread_done(thread_done), .parent_release(parent_release), .first_id(first_id),
    .all_done(all_done), .aborted(aborted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor: every cycle the pulse outputs must equal the queued expectation (or zero)
  always @(negedge clk) if (mon_en) begin
    exp_t e;
    while (q.size() > 0 && q[0].c < cyc) begin
      fails++;
      $display("FAIL missed_event cyc=%0d expected at cyc=%0d", cyc, q[0].c);
      void'(q.pop_front());
    end
    e = '{cyc, 4'b0, 1'b0, 1'b0, 1'b0};
    if (q.size() > 0 && q[0].c == cyc) e = q.pop_front();
    tests++;
    if ({thread_done, parent_release, all_done, aborted} !== {e.dm, e.rel, e.ad, e.ab}) begin
      fails++;
      $display("FAIL pulses cyc=%0d got done=%b rel=%b all=%b ab=%b exp done=%b rel=%b all=%b ab=%b",
               cyc, thread_done, parent_release, all_done, aborted, e.dm, e.rel, e.ad, e.ab);
    end
  end

  task automatic exp_add(input int c, input logic [3:0] dm, input logic r, input logic a, input logic b);
    int k = 0;
    while (k < q.size() && q[k].c < c) k++;
    if (k < q.size() && q[k].c == c) begin
      q[k].dm = q[k].dm | dm;
      q[k].rel = q[k].rel | r;
      q[k].ad = q[k].ad | a;
      q[k].ab = q[k].ab | b;
    end else q.insert(k, '{c, dm, r, a, b});
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_fork(input logic [1:0] m, input logic [3:0] en, input logic [31:0] d, output int t0);
    start = 1'b1;
    mode = m;
    thread_en = en;
    delays = d;
    @(posedge clk);
    #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  // Reference model: child i done at t0+d_i+1; release time depends on mode
  task automatic run_fork(input logic [1:0] m, input logic [3:0] en, input logic [31:0] d,
                          output int t0, output int tl, output int first);
    int mn = 1 << 30;
    int mx = 0;
    logic [1:0] em;
    do_fork(m, en, d, t0);
    em = (m == 2'b11) ? 2'b00 : m;
    first = 0;
    if (en == 4'b0) begin
      exp_add(t0 + 1, 4'b0, 1'b1, 1'b1, 1'b0);
      tl = t0 + 1;
    end else begin
      for (int i = 0; i < 4; i++) if (en[i]) begin
        int tc = t0 + int'(d[i*8 +: 8]) + 1;
        exp_add(tc, 4'(1 << i), 1'b0, 1'b0, 1'b0);
        if (tc < mn) begin
          mn = tc;
          first = i;
        end
        if (tc > mx) mx = tc;
      end
      exp_add(mx, 4'b0, em == 2'b00, 1'b1, 1'b0);
      if (em == 2'b01) exp_add(mn, 4'b0, 1'b1, 1'b0, 1'b0);
      if (em == 2'b10) exp_add(t0 + 1, 4'b0, 1'b1, 1'b0, 1'b0);
      tl = mx;
    end
  endtask

  task automatic test_reset;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if ({busy, thread_active, thread_done, parent_release, all_done, aborted, first_id} !== '0) begin
      fails++;
      $display("FAIL reset_state got busy=%b act=%b done=%b rel=%b all=%b ab=%b fid=%0d exp all zero",
               busy, thread_active, thread_done, parent_release, all_done, aborted, first_id);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_join;
    int t0, tl, f;
    run_fork(2'b00, 4'b0111, {8'd0, 8'd7, 8'd5, 8'd2}, t0, tl, f);
    tests++;
    if (busy !== 1'b1 || thread_active !== 4'b0111) begin
      fails++;
      $display("FAIL join_launch got busy=%b act=%b exp busy=1 act=0111", busy, thread_active);
    end
    wait_until(t0 + 8);
    tests++;
    if (busy !== 1'b0 || tl !== t0 + 8) begin
      fails++;
      $display("FAIL join_busy_end got busy=%b last=%0d exp busy=0 last=%0d", busy, tl - t0, 8);
    end
    wait_until(t0 + 10);
  endtask

  task automatic test_join_none;
    int t0, tl, f;
    run_fork(2'b10, 4'b0111, {8'd0, 8'd7, 8'd5, 8'd2}, t0, tl, f);
    wait_until(t0 + 3);
    start = 1'b1;
    thread_en = 4'b1111;
    delays = '0;
    mode = 2'b00;
    @(posedge clk);
    #1;
    start = 1'b0;
    tests++;
    if (thread_active !== 4'b0110 || busy !== 1'b1) begin
      fails++;
      $display("FAIL ignored_start got act=%b busy=%b exp act=0110 busy=1", thread_active, busy);
    end
    wait_until(tl + 2);
  endtask

  task automatic test_join_any;
    int t0, tl, f;
    run_fork(2'b01, 4'b1111, {8'd9, 8'd4, 8'd4, 8'd12}, t0, tl, f);
    wait_until(t0 + 5);
    tests++;
    if (first_id !== 2'(f) || f !== 1) begin
      fails++;
      $display("FAIL join_any_first_id got %0d exp 1", first_id);
    end
    wait_until(t0 + 13);
    tests++;
    if (first_id !== 2'd1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL join_any_hold got fid=%0d busy=%b exp fid=1 busy=0", first_id, busy);
    end
    wait_until(t0 + 15);
  endtask

  task automatic test_kill;
    int t0, t1, tl, f;
    do_fork(2'b00, 4'b0011, {16'd0, 8'd30, 8'd20}, t0);
    exp_add(t0 + 11, 4'b0, 1'b0, 1'b0, 1'b1);
    wait_until(t0 + 10);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    tests++;
    if (busy !== 1'b0 || thread_active !== 4'b0) begin
      fails++;
      $display("FAIL kill_state got busy=%b act=%b exp busy=0 act=0000", busy, thread_active);
    end
    run_fork(2'b00, 4'b0001, {24'd0, 8'd1}, t1, tl, f);
    tests++;
    if (t1 !== t0 + 12 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_after_kill got t0=+%0d busy=%b exp +12 busy=1", t1 - t0, busy);
    end
    wait_until(tl + 2);
    kill = 1'b1;
    wait_until(tl + 5);
    kill = 1'b0;
  endtask

  task automatic test_empty;
    int t0, tl, f;
    run_fork(2'b01, 4'b0000, 32'hffff_ffff, t0, tl, f);
    tests++;
    if (busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_busy got %b exp 0", busy);
    end
    wait_until(t0 + 1);
    tests++;
    if (first_id !== 2'd0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL empty_first_id got fid=%0d busy=%b exp 0 0", first_id, busy);
    end
    wait_until(t0 + 3);
  endtask

  task automatic test_max_delay;
    int t0, tl, f;
    run_fork(2'b11, 4'b0001, {24'd0, 8'd255}, t0, tl, f);
    wait_until(t0 + 255);
    tests++;
    if (busy !== 1'b1 || thread_active !== 4'b0001) begin
      fails++;
      $display("FAIL max_delay_pending got busy=%b act=%b exp 1 0001", busy, thread_active);
    end
    wait_until(t0 + 258);
  endtask

  task automatic test_back_to_back;
    int t0, t1, tl, f;
    run_fork(2'b00, 4'b1000, {8'd1, 24'd0}, t0, tl, f);
    wait_until(tl);
    run_fork(2'b01, 4'b1010, {8'd3, 8'd0, 8'd0, 8'd0}, t1, tl, f);
    tests++;
    if (t1 !== t0 + 3 || thread_active !== 4'b1010) begin
      fails++;
      $display("FAIL back_to_back got t0=+%0d act=%b exp +3 1010", t1 - t0, thread_active);
    end
    wait_until(tl + 2);
  endtask

  task automatic test_async_reset;
    int t0, tl, f;
    run_fork(2'b00, 4'b0011, {16'd0, 8'd6, 8'd2}, t0, tl, f);
    wait_until(t0 + 3);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    tests++;
    if ({busy, thread_active, thread_done, parent_release, all_done, aborted} !== '0) begin
      fails++;
      $display("FAIL async_reset got busy=%b act=%b done=%b rel=%b all=%b ab=%b exp all zero",
               busy, thread_active, thread_done, parent_release, all_done, aborted);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  initial begin
    test_reset;
    test_join;
    test_join_none;
    test_join_any;
    test_kill;
    test_empty;
    test_max_delay;
    test_back_to_back;
    test_async_reset;
    repeat (5) @(posedge clk);
    #1;
    tests++;
    if (q.size() !== 0) begin
      fails++;
      $display("FAIL scoreboard_drain got %0d pending exp 0", q.size());
    end
    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
